// File: rtl/stack_ram_ctrl.sv
// Burst read/write controller around an inferred single-port-style RAM; one word per cycle.
// Optional STACK_RAM_BOUNDS_CHECK_EN rejects requests that run past the end of the RAM.
module stack_ram_ctrl #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter int BURST_MAX = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rd_start,
  input  logic                        wr_start,
  input  logic [15:0]                 address,
  input  logic [15:0]                 words,
  input  logic [BURST_MAX*DATA_W-1:0] wr_data,
  output logic [BURST_MAX*DATA_W-1:0] rd_data,
  output logic                        done,
  output logic                        busy,
  output logic                        error
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int PW = BURST_MAX * DATA_W;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_last;
  logic              r_is_wr;
  logic [PW-1:0]     r_wr_buf;
  logic [PW-1:0]     r_rd_buf;
  logic [PW-1:0]     r_rd_data;
  logic [DATA_W-1:0] r_ram_q;
  logic              r_done;
  logic              r_busy;
  logic              r_error;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_start;
  logic              w_len_bad;
  logic              w_len_zero;
  logic              w_oob;
  logic              w_reject;
  logic              w_last;
  logic              w_held;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [AW-1:0]     w_ram_waddr;
  logic [AW-1:0]     w_ram_raddr;
  logic [PW-1:0]     w_rd_next;
  logic [DATA_W-1:0] w_wr_lane [BURST_MAX];
  logic              w_unused_addr;

  assign w_start    = rd_start | wr_start;
  assign w_len_bad  = words > 16'(BURST_MAX);
  assign w_len_zero = (words == 16'd0);
`ifdef STACK_RAM_BOUNDS_CHECK_EN
  assign w_oob = ({1'b0, address} >= 17'(DEPTH)) ||
                 (({1'b0, address} + {1'b0, words}) > 17'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif
  assign w_reject      = w_len_bad | w_oob;
  assign w_last        = (r_idx == r_last);
  assign w_held        = r_is_wr ? wr_start : rd_start;
  assign w_unused_addr = &{1'b0, address[15:AW]};

  // The read pipeline starts at the accept edge so the last word lands exactly when done rises.
  assign w_ram_we    = (r_state == WRITE) && !reset;
  assign w_ram_re    = ((r_state == IDLE) && rd_start && !wr_start && !w_reject && !w_len_zero) ||
                       ((r_state == READ) && !w_last);
  assign w_ram_waddr = r_addr + AW'(r_idx);
  assign w_ram_raddr = (r_state == IDLE) ? address[AW-1:0] : (r_addr + AW'(r_idx) + AW'(1));

  generate
    for (genvar gi = 0; gi < BURST_MAX; gi++) begin : g_lane
      assign w_wr_lane[gi] = r_wr_buf[(BURST_MAX-gi)*DATA_W-1 -: DATA_W];
      assign w_rd_next[(BURST_MAX-gi)*DATA_W-1 -: DATA_W] =
        (r_idx == IW'(gi)) ? r_ram_q : r_rd_buf[(BURST_MAX-gi)*DATA_W-1 -: DATA_W];
    end
  endgenerate

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_ram_waddr] <= w_wr_lane[r_idx];
    if (w_ram_re) r_ram_q <= r_mem[w_ram_raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_rd_data <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr   <= address[AW-1:0];
            r_last   <= IW'(words - 16'd1);
            r_is_wr  <= wr_start;
            r_wr_buf <= wr_data;
            r_rd_buf <= '0;
            r_idx    <= '0;
            if (w_reject) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else if (w_len_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= wr_start ? WRITE : READ;
              r_busy  <= 1'b1;
            end
          end
        end
        READ: begin
          r_rd_buf <= w_rd_next;
          r_idx    <= r_idx + IW'(1);
          if (w_last) begin
            r_rd_data <= w_rd_next;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        WRITE: begin
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          if (!w_held) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign done    = r_done;
  assign busy    = r_busy;
  assign error   = r_error;

endmodule
